deserializer_rx: RTL and testbench

- Receive-side counterpart of the team's MSB-first serializer.
- Samples a serial bit stream qualified by a valid flag and assembles MSG_SIZE-bit words, MSB first.
- Presents each word on a parallel bus with a bit counter, a valid handshake and a sticky overflow flag.
- oCounter reaches MSG_SIZE when a word is complete, so it can drive a downstream serializer's counter input directly for loopback and echo paths.

---
 rtl/ser_pkg.sv | 20 ++
 rtl/deserializer_rx.sv | 94 +++++++++
 tb/tb_deserializer_rx.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// Shared definitions for the serial link: word size, counter width
// derivation and the receiver state encoding. The serializer and any
// loopback top reuse these so both ends agree on widths.
package ser_pkg;

    // Default word length in bits.
    localparam int MSG_SIZE_DEF = 64;

    // Counter must be able to hold the value MSG_SIZE itself, not just MSG_SIZE-1.
    function automatic int cw_of(input int msg_size);
        return $clog2(msg_size) + 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } rx_state_t;

endpackage

// File: rtl/deserializer_rx.sv
// MSB-first serial-to-parallel receiver. Assembles MSG_SIZE-bit words from a
// flagged bit stream, holds each completed word until acknowledged and flags
// bits that arrive while a word is still waiting (sticky overflow).
// oCounter reaches MSG_SIZE on completion so it can drive a serializer's
// counter input directly in loopback/echo paths.
module deserializer_rx
    import ser_pkg::*;
#(
    parameter int MSG_SIZE = MSG_SIZE_DEF,
    localparam int CW = cw_of(MSG_SIZE)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                iClear,
    input  logic                iData_in,
    input  logic                iData_flag,
    input  logic                iAck,
    output logic [MSG_SIZE-1:0] oData_out,
    output logic [CW-1:0]       oCounter,
    output logic                oData_valid,
    output logic                oOverflow
);

    localparam logic [CW-1:0] CNT_FULL = CW'(MSG_SIZE);
    localparam logic [CW-1:0] CNT_LAST = CW'(MSG_SIZE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    rx_state_t state;

    // State, counter, shift register and flags in one registered process;
    // priority is reset > enable-freeze > clear > normal operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            oData_out   <= '0;
            oCounter    <= '0;
            oData_valid <= 1'b0;
            oOverflow   <= 1'b0;
        end else if (ena) begin
            if (iClear) begin
                state       <= IDLE;
                oData_out   <= '0;
                oCounter    <= '0;
                oData_valid <= 1'b0;
                oOverflow   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (iData_flag) begin
                            oData_out <= {oData_out[MSG_SIZE-2:0], iData_in};
                            oCounter  <= CNT_ONE;
                            state     <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (iData_flag) begin
                            oData_out <= {oData_out[MSG_SIZE-2:0], iData_in};
                            if (oCounter == CNT_LAST) begin
                                oCounter    <= CNT_FULL;
                                oData_valid <= 1'b1;
                                state       <= FULL;
                            end else begin
                                oCounter <= oCounter + CNT_ONE;
                            end
                        end
                    end
                    FULL: begin
                        if (iAck) begin
                            oData_valid <= 1'b0;
                            // A bit arriving with the ack starts the next word.
                            if (iData_flag) begin
                                oData_out <= {oData_out[MSG_SIZE-2:0], iData_in};
                                oCounter  <= CNT_ONE;
                                state     <= SHIFT;
                            end else begin
                                oCounter <= '0;
                                state    <= IDLE;
                            end
                        end else if (iData_flag) begin
                            oOverflow <= 1'b1;
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        oCounter    <= '0;
                        oData_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_deserializer_rx.sv
// Randomized and directed bench for deserializer_rx (MSG_SIZE=8). A bit-queue
// reference model tracks the word being received; every clock all outputs are
// compared against it, plus explicit end-of-scenario word checks.
module tb_deserializer_rx;
    import ser_pkg::*;

    localparam int N  = 8;
    localparam int CW = cw_of(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic          iClear;
    logic          iData_in;
    logic          iData_flag;
    logic          iAck;
    logic [N-1:0]  oData_out;
    logic [CW-1:0] oCounter;
    logic          oData_valid;
    logic          oOverflow;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: bits of the word in progress, the visible data word,
    // and the valid/overflow flags.
    bit           m_q[$];
    logic [N-1:0] m_data;
    logic         m_valid;
    logic         m_ovf;

    deserializer_rx #(.MSG_SIZE(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .iClear     (iClear),
        .iData_in   (iData_in),
        .iData_flag (iData_flag),
        .iAck       (iAck),
        .oData_out  (oData_out),
        .oCounter   (oCounter),
        .oData_valid(oData_valid),
        .oOverflow  (oOverflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_q.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
    endfunction

    function automatic void m_push(input bit b);
        m_data = {m_data[N-2:0], b};
        m_q.push_back(b);
        if (m_q.size() == N) m_valid = 1'b1;
    endfunction

    // One clock of the model, using the inputs present at the edge.
    function automatic void m_step();
        if (!rst_n) begin
            m_reset();
        end else if (ena) begin
            if (iClear) begin
                m_reset();
            end else if (m_valid) begin
                if (iAck) begin
                    m_valid = 1'b0;
                    m_q.delete();
                    if (iData_flag) m_push(iData_in);
                end else if (iData_flag) begin
                    m_ovf = 1'b1;
                end
            end else if (iData_flag) begin
                m_push(iData_in);
            end
        end
    endfunction

    task automatic check_all(input string where);
        chk({where, ".data"}, oData_out, m_data);
        chk({where, ".cnt"}, oCounter, m_q.size());
        chk({where, ".valid"}, oData_valid, m_valid);
        chk({where, ".ovf"}, oOverflow, m_ovf);
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
        check_all("cyc");
    endtask

    task automatic drv(input logic e, input logic f, input logic d,
                       input logic a, input logic c);
        ena = e; iData_flag = f; iData_in = d; iAck = a; iClear = c;
        tick();
    endtask

    task automatic send_word(input logic [N-1:0] w);
        for (int i = N - 1; i >= 0; i--) drv(1'b1, 1'b1, w[i], 1'b0, 1'b0);
    endtask

    task automatic ack();
        drv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [N-1:0] w;
        int idx;
        rst_n = 1'b0; ena = 1'b0; iClear = 1'b0; iData_in = 1'b0;
        iData_flag = 1'b0; iAck = 1'b0;
        m_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;
        tick();

        // Basic word A5.
        send_word(8'hA5);
        chk("basic.word", oData_out, 8'hA5);
        chk("basic.cnt", oCounter, 8);
        chk("basic.valid", oData_valid, 1'b1);
        ack();
        chk("basic.ack_cnt", oCounter, 0);
        chk("basic.ack_valid", oData_valid, 1'b0);

        // Gapped word 3C: flag gaps and enable-low cycles mid-word.
        w = 8'h3C;
        for (int i = N - 1; i >= 0; i--) begin
            if (i == 3) for (int g = 0; g < 3; g++) drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            if (i == 1) for (int g = 0; g < 2; g++) drv(1'b0, 1'b1, 1'($urandom), 1'b1, 1'b1);
            drv(1'b1, 1'b1, w[i], 1'b0, 1'b0);
            chk("gap.cnt", oCounter, N - i);
        end
        chk("gap.word", oData_out, 8'h3C);

        // Overflow and back-to-back start.
        ack();
        send_word(8'hFF);
        drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("ovf.word", oData_out, 8'hFF);
        chk("ovf.flag", oOverflow, 1'b1);
        drv(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("b2b.cnt", oCounter, 1);
        chk("b2b.valid", oData_valid, 1'b0);
        chk("b2b.ovf", oOverflow, 1'b1);

        // Abort mid-word, then word 81.
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) drv(1'b1, 1'b1, 1'($urandom), 1'b0, 1'b0);
        drv(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("abort.cnt", oCounter, 0);
        chk("abort.data", oData_out, 8'h00);
        chk("abort.ovf", oOverflow, 1'b0);
        send_word(8'h81);
        chk("abort.word", oData_out, 8'h81);
        ack();

        // Asynchronous reset between edges after 3 bits.
        for (int i = 0; i < 3; i++) drv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.data", oData_out, 8'h00);
        chk("arst.cnt", oCounter, 0);
        chk("arst.valid", oData_valid, 1'b0);
        m_reset();
        drv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        send_word(8'h5A);
        chk("arst.word", oData_out, 8'h5A);
        ack();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drv(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7), 1'($urandom),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 49) == 0));
        end

        // Loopback: a serializer indexed by oCounter feeds the receiver.
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        w = 8'hA5;
        for (int i = 0; i < 12; i++) begin
            idx = int'(oCounter);
            if (idx < N) drv(1'b1, 1'b1, w[N-1-idx], 1'b0, 1'b0);
            else         drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("loop.word", oData_out, 8'hA5);
        chk("loop.flag", iData_flag, 1'b0);
        chk("loop.ovf", oOverflow, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
